// File: rtl/quad_pkg.sv
// quad_pkg: shared AB phase constants and quadrature step / counter arithmetic helpers
package quad_pkg;
  localparam logic [1:0] S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10;
  function automatic logic [1:0] phase(input logic [1:0] s);
    return s == S00 ? 2'd0 : s == S01 ? 2'd1 : s == S11 ? 2'd2 : s == S10 ? 2'd3 : 2'd0;
  endfunction
  // Returns {illegal, dir(1=up), move}; a phase distance of 2 means both pins changed.
  function automatic logic [2:0] quad_step(input logic [1:0] prev, input logic [1:0] nxt);
    logic [1:0] d;
    d = phase(nxt) - phase(prev);
    return {d == 2'd2, d == 2'd1, d[0]};
  endfunction
  // value is sign-extended from a w-bit counter (w <= 63); the caller keeps the low w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] value, input logic dir,
                                                 input logic sat, input int w);
    logic signed [63:0] lim;
    lim = dir ? (64'sd1 <<< (w - 1)) - 64'sd1 : -(64'sd1 <<< (w - 1));
    return (sat && value == lim) ? value : dir ? value + 64'sd1 : value - 64'sd1;
  endfunction
endpackage

// File: rtl/quad_decoder_ch.sv
// quad_decoder_ch: one encoder channel with sync, glitch filter, 4x decode, homing and clear
module quad_decoder_ch
  import quad_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int FILT_LEN = 4,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             home,
  input  logic             home_arm,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             homed
);
  localparam int SW = $clog2(FILT_LEN + 1);
  logic [1:0] ab1, ab2, filt, prev;
  logic [2:0] hs;
  logic [SW-1:0] stable;
  logic fv, primed, live, home_ev;
  logic [2:0] step;
  logic [CNT_W-1:0] stepped;
  always_comb begin
    step = quad_step(prev, filt);
    live = fv & primed;
    home_ev = hs[1] & ~hs[2] & home_arm;
    stepped = CNT_W'(sat_add(64'(signed'(count)), step[1], SAT != 0, CNT_W));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ab1 <= '0;
      ab2 <= '0;
      filt <= '0;
      prev <= '0;
      hs <= '0;
      stable <= '0;
      fv <= 1'b0;
      primed <= 1'b0;
      count <= '0;
      err <= 1'b0;
      homed <= 1'b0;
    end else begin
      ab1 <= {a, b};
      ab2 <= ab1;
      stable <= ab1 != ab2 ? SW'(1) : stable == SW'(FILT_LEN) ? stable : stable + 1'b1;
      if (stable == SW'(FILT_LEN)) begin
        filt <= ab2;
        fv <= 1'b1;
      end
      // prev tracks filt even during clear/home so no stale step fires afterwards
      if (fv) begin
        prev <= filt;
        primed <= 1'b1;
      end
      hs <= {hs[1:0], home};
      if (clr) begin
        count <= '0;
        err <= 1'b0;
        homed <= 1'b0;
      end else if (home_ev) begin
        count <= '0;
        homed <= 1'b1;
      end else if (live) begin
        if (step[0]) count <= stepped;
        if (step[2]) err <= 1'b1;
      end
    end
endmodule

// File: rtl/quad_decoder_bank.sv
// quad_decoder_bank: NUM_CH quadrature decoders with a coherent snapshot register bank
module quad_decoder_bank
  import quad_pkg::*;
#(
  parameter int NUM_CH = 12,
  parameter int CNT_W = 32,
  parameter int FILT_LEN = 4,
  parameter int SAT = 0
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [NUM_CH-1:0]       enc_a_i,
  input  logic [NUM_CH-1:0]       enc_b_i,
  input  logic [NUM_CH-1:0]       home_i,
  input  logic [NUM_CH-1:0]       home_arm_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic                    snap_i,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH*CNT_W-1:0] snap_count_o,
  output logic                    snap_valid_o,
  output logic [NUM_CH-1:0]       err_o,
  output logic [NUM_CH-1:0]       homed_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quad_decoder_ch #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .SAT(SAT)) u_ch (
      .clk(clk_clk),
      .rst(reset_reset),
      .a(enc_a_i[g]),
      .b(enc_b_i[g]),
      .home(home_i[g]),
      .home_arm(home_arm_i[g]),
      .clr(clr_i[g]),
      .count(count_o[g*CNT_W +: CNT_W]),
      .err(err_o[g]),
      .homed(homed_o[g])
    );
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      snap_count_o <= '0;
      snap_valid_o <= 1'b0;
    end else begin
      snap_valid_o <= snap_i;
      if (snap_i) snap_count_o <= count_o;
    end
endmodule

// File: tb/tb_quad_decoder_bank.sv
// tb_quad_decoder_bank: directed + random checks of a wrapping and a saturating 4-channel bank
module tb_quad_decoder_bank;
  localparam int N = 4, W = 8, F = 4;
  logic clk = 1'b0, rst = 1'b1, snap = 1'b0;
  logic [N-1:0] a = '0, b = '0, home = '0, arm = '0, clr = '0;
  logic [N*W-1:0] cnt_w, cnt_s, snap_w, snap_s;
  logic vw, vs;
  logic [N-1:0] err_w, err_s, homed_w, homed_s;
  int n_assert = 0, n_fail = 0;
  int pos[N], m_w[N], m_s[N];
  bit m_err[N], m_homed[N];
  logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 clk = ~clk;

  quad_decoder_bank #(.NUM_CH(N), .CNT_W(W), .FILT_LEN(F), .SAT(0)) dut (
    .clk_clk(clk), .reset_reset(rst), .enc_a_i(a), .enc_b_i(b), .home_i(home),
    .home_arm_i(arm), .clr_i(clr), .snap_i(snap), .count_o(cnt_w), .snap_count_o(snap_w),
    .snap_valid_o(vw), .err_o(err_w), .homed_o(homed_w));
  quad_decoder_bank #(.NUM_CH(N), .CNT_W(W), .FILT_LEN(F), .SAT(1)) dut_s (
    .clk_clk(clk), .reset_reset(rst), .enc_a_i(a), .enc_b_i(b), .home_i(home),
    .home_arm_i(arm), .clr_i(clr), .snap_i(snap), .count_o(cnt_s), .snap_count_o(snap_s),
    .snap_valid_o(vs), .err_o(err_s), .homed_o(homed_s));

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int wrap(input int v);
    return ((v + 128) & 255) - 128;
  endfunction

  function automatic int clamp(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction

  task automatic setpins(input int ch);
    {a[ch], b[ch]} = gray[pos[ch]];
  endtask

  task automatic step(input int ch, input int d, input int hold);
    pos[ch] = (pos[ch] + d) & 3;
    setpins(ch);
    m_w[ch] = wrap(m_w[ch] + d);
    m_s[ch] = clamp(m_s[ch] + d);
    cyc(hold);
  endtask

  task automatic mclr(input int ch);
    m_w[ch] = 0;
    m_s[ch] = 0;
    m_err[ch] = 0;
    m_homed[ch] = 0;
  endtask

  task automatic pulse_clr(input int ch);
    clr[ch] = 1'b1;
    cyc(1);
    clr[ch] = 1'b0;
    mclr(ch);
    cyc(2);
  endtask

  task automatic chk_ch(input int ch);
    chk($sformatf("count_wrap ch%0d", ch), 32'(cnt_w[ch*W +: W]), 32'(m_w[ch]) & 32'hff);
    chk($sformatf("count_sat ch%0d", ch), 32'(cnt_s[ch*W +: W]), 32'(m_s[ch]) & 32'hff);
    chk($sformatf("err ch%0d", ch), {31'b0, err_w[ch]}, {31'b0, m_err[ch]});
    chk($sformatf("err_sat ch%0d", ch), {31'b0, err_s[ch]}, {31'b0, m_err[ch]});
    chk($sformatf("homed ch%0d", ch), {31'b0, homed_w[ch]}, {31'b0, m_homed[ch]});
    chk($sformatf("homed_sat ch%0d", ch), {31'b0, homed_s[ch]}, {31'b0, m_homed[ch]});
  endtask

  initial begin
    int n, base, req, prev_req, exp_snap;
    logic [W-1:0] old;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0;
      mclr(i);
    end
    cyc(3);
    chk("reset count", cnt_w, '0);
    chk("reset snap", snap_w, '0);
    chk("reset valid", {31'b0, vw}, 32'd0);
    chk("reset err", {28'b0, err_w}, 32'd0);
    chk("reset homed", {28'b0, homed_w}, 32'd0);
    rst = 1'b0;
    cyc(20);
    // forward: latency of the first step, then 32 steps total
    old = cnt_w[W-1:0];
    pos[0] = 1;
    setpins(0);
    n = 0;
    while (cnt_w[W-1:0] === old && n < 20) begin
      cyc(1);
      n++;
    end
    chk("first step latency", n, F + 3);
    m_w[0] = 1;
    m_s[0] = 1;
    cyc(10 - n);
    for (int i = 1; i < 32; i++) step(0, 1, 10);
    chk_ch(0);
    // glitches on A: 3 clk rejected, 4 clk accepted both ways
    a[0] = 1'b1;
    cyc(F - 1);
    a[0] = 1'b0;
    cyc(12);
    chk_ch(0);
    a[0] = 1'b1;
    cyc(F);
    a[0] = 1'b0;
    cyc(12);
    chk_ch(0);
    // random walk
    for (int i = 0; i < 20; i++) step(2, $urandom_range(0, 1) ? 1 : -1, 8);
    chk_ch(2);
    // illegal transition
    pos[1] = 2;
    setpins(1);
    m_err[1] = 1;
    cyc(10);
    chk_ch(1);
    for (int i = 0; i < 10; i++) step(1, 1, 8);
    chk_ch(1);
    pulse_clr(1);
    chk_ch(1);
    // wrap / saturate boundaries
    pulse_clr(2);
    for (int i = 0; i < 127; i++) step(2, 1, 8);
    chk_ch(2);
    step(2, 1, 8);
    chk_ch(2);
    pulse_clr(2);
    for (int i = 0; i < 128; i++) step(2, -1, 8);
    chk_ch(2);
    step(2, -1, 8);
    chk_ch(2);
    // homing
    arm[3] = 1'b1;
    for (int i = 0; i < 55; i++) step(3, 1, 8);
    home[3] = 1'b1;
    cyc(2);
    chk_ch(3);
    cyc(1);
    m_w[3] = 0;
    m_s[3] = 0;
    m_homed[3] = 1;
    chk_ch(3);
    home[3] = 1'b0;
    cyc(5);
    pulse_clr(3);
    arm[3] = 1'b0;
    for (int i = 0; i < 3; i++) step(3, 1, 8);
    home[3] = 1'b1;
    cyc(6);
    chk_ch(3);
    arm[3] = 1'b1;
    cyc(6);
    chk_ch(3);
    home[3] = 1'b0;
    cyc(5);
    pos[3] = (pos[3] + 1) & 3;
    setpins(3);
    cyc(4);
    home[3] = 1'b1;
    cyc(3);
    m_w[3] = 0;
    m_s[3] = 0;
    m_homed[3] = 1;
    cyc(10);
    chk_ch(3);
    home[3] = 1'b0;
    cyc(5);
    // snapshot while ch1 steps every 5 clk with random snap requests
    base = m_w[1];
    prev_req = 0;
    exp_snap = 0;
    for (int c = 0; c < 60; c++) begin
      n = c < F + 3 ? 0 : (c - F - 3) / 5 + 1;
      chk($sformatf("live ch1 c%0d", c), 32'(cnt_w[W +: W]), 32'(base + n) & 32'hff);
      chk($sformatf("snap_valid c%0d", c), {31'b0, vw}, 32'(prev_req));
      if (prev_req != 0) begin
        chk($sformatf("snap ch1 c%0d", c), 32'(snap_w[W +: W]), 32'(exp_snap) & 32'hff);
        chk($sformatf("snap ch3 c%0d", c), 32'(snap_s[3*W +: W]), 32'(m_s[3]) & 32'hff);
      end
      if (c % 5 == 0) begin
        pos[1] = (pos[1] + 1) & 3;
        setpins(1);
      end
      req = int'($urandom_range(0, 1));
      snap = req[0];
      exp_snap = base + n;
      prev_req = req;
      cyc(1);
    end
    snap = 1'b0;
    m_w[1] = base + 12;
    m_s[1] = base + 12;
    cyc(15);
    chk_ch(1);
    // reset mid-pulse, then release with pins resting at 11
    snap = 1'b1;
    cyc(1);
    chk("valid before reset", {31'b0, vw}, 32'd1);
    snap = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("valid in reset", {31'b0, vw}, 32'd0);
    chk("count in reset", cnt_w, '0);
    for (int i = 0; i < N; i++) begin
      pos[i] = 2;
      setpins(i);
      mclr(i);
    end
    arm = '0;
    cyc(3);
    rst = 1'b0;
    cyc(30);
    for (int i = 0; i < N; i++) chk_ch(i);
    step(0, 1, 12);
    chk_ch(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
